mailbox_fetch: RTL and testbench

- Bus master for the 8-bit right port of the 2Kx16 dual-port mailbox; it stands in for the sub-CPU side.
- On a mailbox interrupt it acknowledges the interrupt, reads a length-prefixed message out of shared RAM and streams the bytes downstream with valid/ready.
- When the message is done it writes a reply byte that raises the left-side interrupt to the main CPU.
- It sits directly downstream of the mailbox and feeds the sound/MCU command logic.

---
 rtl/mailbox_fetch_if.sv | 27 ++
 rtl/mailbox_fetch.sv | 130 +++++++++++++
 tb/tb_mailbox_fetch.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mailbox_fetch_if.sv
// Right-port bus of the dual-port mailbox plus the downstream byte stream.
// The master side is the fetch engine; the slave side is the mailbox RAM and the stream sink.
interface mailbox_fetch_if;
    logic        mb_cs;
    logic [11:0] mb_addr;
    logic [7:0]  mb_din;
    logic        mb_we;
    logic [7:0]  mb_dout;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;

    modport master (
        output mb_cs, mb_addr, mb_din, mb_we,
        input  mb_dout,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  mb_cs, mb_addr, mb_din, mb_we,
        output mb_dout,
        input  out_valid, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/mailbox_fetch.sv
// Sub-CPU stand-in on the mailbox right port: on int_r it acknowledges by reading the length
// byte, streams that many payload bytes out over valid/ready, then writes a reply byte that
// raises the main-CPU interrupt.
module mailbox_fetch #(
    parameter logic [11:0] BASE_ADDR  = 12'h000,
    parameter int unsigned MAX_LEN    = 64,
    parameter logic [11:0] LEN_ADDR   = 12'hFFF,
    parameter logic [11:0] REPLY_ADDR = 12'hFFC
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            int_r,
    output logic            busy,
    mailbox_fetch_if.master bus
);
    localparam logic [7:0] MaxLen = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        StIdle,
        StLenWait,
        StRd,
        StRdWait,
        StOut,
        StReply
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_last_q, out_last_d;

    // State and stream registers; reset discards any message in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= 8'h00;
            cnt_q       <= 8'h00;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Next-state logic and the mailbox bus strobes, which are only active in issue cycles.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        bus.mb_cs   = 1'b0;
        bus.mb_we   = 1'b0;
        bus.mb_addr = 12'h000;
        bus.mb_din  = 8'h00;

        unique case (state_q)
            StIdle: begin
                // Gate with reset so a pending interrupt cannot strobe the bus while held in reset.
                if (int_r && !reset) begin
                    bus.mb_cs   = 1'b1;
                    bus.mb_addr = LEN_ADDR;
                    state_d     = StLenWait;
                end
            end
            StLenWait: begin
                if (bus.mb_dout > MaxLen) begin
                    err_d = 1'b1;
                    cnt_d = MaxLen;
                end else begin
                    err_d = 1'b0;
                    cnt_d = bus.mb_dout;
                end
                idx_d   = 8'h00;
                state_d = (cnt_d == 8'h00) ? StReply : StRd;
            end
            StRd: begin
                bus.mb_cs   = 1'b1;
                bus.mb_addr = BASE_ADDR + {4'h0, idx_q};
                state_d     = StRdWait;
            end
            StRdWait: begin
                out_data_d  = bus.mb_dout;
                out_valid_d = 1'b1;
                out_last_d  = (idx_q == cnt_q - 8'd1);
                state_d     = StOut;
            end
            StOut: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d = StReply;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        state_d = StRd;
                    end
                end
            end
            StReply: begin
                bus.mb_cs   = 1'b1;
                bus.mb_we   = 1'b1;
                bus.mb_addr = REPLY_ADDR;
                bus.mb_din  = err_q ? 8'hFF : cnt_q;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q != StIdle);
endmodule

// File: tb/tb_mailbox_fetch.sv
// Bench for mailbox_fetch: a mailbox RAM model answers the right port, a queue-based model
// predicts the byte stream and reply per message, and a negedge monitor compares every cycle.
module tb_mailbox_fetch;
    localparam int MaxLen = 64;

    logic clk = 1'b0;
    logic reset;
    logic int_r;
    logic busy;
    logic out_ready;

    mailbox_fetch_if mb ();

    mailbox_fetch #(
        .BASE_ADDR (12'h000),
        .MAX_LEN   (64),
        .LEN_ADDR  (12'hFFF),
        .REPLY_ADDR(12'hFFC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .int_r(int_r),
        .busy (busy),
        .bus  (mb)
    );

    always #5 clk = ~clk;

    // Mailbox RAM and interrupt model
    logic [7:0] mem [4096];
    logic [7:0] mb_dout_q = 8'h00;
    logic       int_r_q = 1'b0;
    int         done_cnt = 0;
    int         req_cnt = 0;
    logic [7:0] req_len, req_b0, req_step;
    bit         req_defer;
    int         cyc = 0;

    assign mb.mb_dout   = mb_dout_q;
    assign mb.out_ready = out_ready;
    assign int_r        = int_r_q;

    always @(posedge clk) cyc <= cyc + 1;

    // Deferred messages land in RAM on the reply write, as if the main CPU reloaded on int_l.
    always @(posedge clk) begin
        if (mb.mb_cs && !mb.mb_we) begin
            mb_dout_q <= mem[mb.mb_addr];
            if (mb.mb_addr == 12'hFFF) int_r_q <= 1'b0;
        end
        if (mb.mb_cs && mb.mb_we) mem[mb.mb_addr] <= mb.mb_din;
        if (req_cnt != done_cnt) begin
            if (!req_defer || (mb.mb_cs && mb.mb_we)) begin
                mem[12'hFFF] <= req_len;
                for (int k = 0; k < int'(req_len); k++) mem[12'(k)] <= req_b0 + 8'(k) * req_step;
                done_cnt <= done_cnt + 1;
            end
            int_r_q <= 1'b1;
        end
    end

    // Expected and observed traffic
    logic [7:0] exp_data[$];
    bit         exp_last[$];
    logic [7:0] exp_reply[$];
    logic [7:0] got_data[$];
    bit         got_last[$];
    logic [7:0] got_reply[$];
    int         len_cycs[$];
    int         reply_cycs[$];
    int         rise_cycs[$];
    int         n_reads = 0;
    int         n_writes = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Model: stream is min(len, MAX_LEN) payload bytes, last on the final one; reply is the
    // count, or FF when the length was clipped.
    task automatic post_msg(input int len, input logic [7:0] b0, input logic [7:0] step,
                            input bit defer);
        int cnt;
        cnt = (len > MaxLen) ? MaxLen : len;
        for (int i = 0; i < cnt; i++) begin
            exp_data.push_back(b0 + 8'(i) * step);
            exp_last.push_back(i == cnt - 1);
        end
        exp_reply.push_back((len > MaxLen) ? 8'hFF : 8'(len));
        req_len   = 8'(len);
        req_b0    = b0;
        req_step  = step;
        req_defer = defer;
        req_cnt++;
    endtask

    // Per-cycle monitor
    bit         prev_stall = 1'b0;
    bit         prev_valid = 1'b0;
    logic [7:0] prev_data;
    bit         prev_last;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", mb.out_valid, 1'b1);
                check("stall_data", mb.out_data, prev_data);
                check("stall_last", mb.out_last, prev_last);
            end
            if (mb.out_valid && !prev_valid) rise_cycs.push_back(cyc);
            if (mb.out_valid && mb.out_ready) begin
                n_tests++;
                if (exp_data.size() == 0) begin
                    n_fail++;
                    $display("FAIL stream_extra: got byte %0h, required no byte", mb.out_data);
                end else begin
                    check("stream_data", mb.out_data, exp_data.pop_front());
                    check("stream_last", mb.out_last, exp_last.pop_front());
                end
                got_data.push_back(mb.out_data);
                got_last.push_back(mb.out_last);
            end
            if (mb.mb_cs && mb.mb_we) begin
                n_writes++;
                reply_cycs.push_back(cyc);
                got_reply.push_back(mb.mb_din);
                check("reply_addr", mb.mb_addr, 12'hFFC);
                n_tests++;
                if (exp_reply.size() == 0) begin
                    n_fail++;
                    $display("FAIL reply_extra: got write %0h, required none", mb.mb_din);
                end else begin
                    check("reply_data", mb.mb_din, exp_reply.pop_front());
                end
            end else if (mb.mb_cs) begin
                n_reads++;
                if (mb.mb_addr == 12'hFFF) len_cycs.push_back(cyc);
                check("rd_din_zero", mb.mb_din, 8'h00);
            end else begin
                check("bus_idle", {mb.mb_we, mb.mb_din, mb.mb_addr}, 21'h0);
            end
            prev_stall = mb.out_valid && !mb.out_ready;
            prev_valid = mb.out_valid;
            prev_data  = mb.out_data;
            prev_last  = mb.out_last;
        end
    end

    task automatic wait_done(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            ok = (exp_data.size() == 0) && (exp_reply.size() == 0) && !busy &&
                 (req_cnt == done_cnt) && !int_r;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: got busy=%0d pending=%0d, required idle with 0 pending",
                     name, busy, exp_data.size());
        end
    endtask

    task automatic wait_valid(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clk);
            ok = mb.out_valid;
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: got out_valid=0, required 1", name);
        end
    endtask

    task automatic clear_obs();
        got_data.delete();
        got_last.delete();
        got_reply.delete();
        len_cycs.delete();
        reply_cycs.delete();
        rise_cycs.delete();
    endtask

    initial begin
        int rd_snap;
        int wr_snap;
        int n_lasts;
        reset     = 1'b1;
        out_ready = 1'b1;

        // Reset with an interrupt already pending: nothing may move on the outputs.
        post_msg(3, 8'h11, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        check("reset_int_pending", int_r, 1'b1);
        check("reset_cs", mb.mb_cs, 1'b0);
        check("reset_we", mb.mb_we, 1'b0);
        check("reset_addr", mb.mb_addr, 12'h000);
        check("reset_din", mb.mb_din, 8'h00);
        check("reset_valid", mb.out_valid, 1'b0);
        check("reset_data", mb.out_data, 8'h00);
        check("reset_last", mb.out_last, 1'b0);
        check("reset_busy", busy, 1'b0);

        // Happy path: 11,22,33 then reply 03
        @(posedge clk);
        #1 reset = 1'b0;
        wait_done("happy", 60);
        check("happy_n", got_data.size(), 3);
        check("happy_b0", got_data[0], 8'h11);
        check("happy_b1", got_data[1], 8'h22);
        check("happy_b2", got_data[2], 8'h33);
        check("happy_lasts", {got_last[0], got_last[1], got_last[2]}, 3'b001);
        check("happy_reply", got_reply[0], 8'h03);
        check("happy_writes", n_writes, 1);
        check("happy_len_reads", len_cycs.size(), 1);
        check("happy_latency", rise_cycs[0] - len_cycs[0], 4);
        check("happy_busy", busy, 1'b0);

        // Backpressure: 5-cycle stall on byte 0 must not cause extra reads
        clear_obs();
        @(posedge clk);
        #1 out_ready = 1'b0;
        post_msg(2, 8'hA0, 8'h05, 1'b0);
        wait_valid("bp", 40);
        rd_snap = n_reads;
        repeat (5) @(negedge clk);
        check("bp_no_extra_reads", n_reads, rd_snap);
        check("bp_held_valid", mb.out_valid, 1'b1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_done("bp", 60);
        check("bp_n", got_data.size(), 2);
        check("bp_b0", got_data[0], 8'hA0);
        check("bp_b1", got_data[1], 8'hA5);
        check("bp_reply", got_reply[0], 8'h02);

        // Zero length: reply 00 two cycles after the acknowledge, no stream
        clear_obs();
        @(posedge clk);
        #1 post_msg(0, 8'h00, 8'h00, 1'b0);
        wait_done("zero", 40);
        check("zero_n", got_data.size(), 0);
        check("zero_reply", got_reply[0], 8'h00);
        check("zero_timing", reply_cycs[0] - len_cycs[0], 2);

        // Overlength: 200 clipped to 64, reply FF
        clear_obs();
        @(posedge clk);
        #1 post_msg(200, 8'h01, 8'h01, 1'b0);
        wait_done("over", 400);
        n_lasts = 0;
        foreach (got_last[k]) n_lasts += int'(got_last[k]);
        check("over_n", got_data.size(), 64);
        check("over_b63", got_data[63], 8'h40);
        check("over_last63", got_last[63], 1'b1);
        check("over_n_lasts", n_lasts, 1);
        check("over_reply", got_reply[0], 8'hFF);

        // Back-to-back: second interrupt raised mid-stream
        clear_obs();
        @(posedge clk);
        #1 post_msg(3, 8'h30, 8'h01, 1'b0);
        wait_valid("b2b", 40);
        @(posedge clk);
        #1 post_msg(2, 8'h50, 8'h10, 1'b1);
        wait_done("b2b", 100);
        check("b2b_n", got_data.size(), 5);
        check("b2b_b2", got_data[2], 8'h32);
        check("b2b_b3", got_data[3], 8'h50);
        check("b2b_b4", got_data[4], 8'h60);
        check("b2b_replies", {got_reply[0], got_reply[1]}, 16'h0302);
        check("b2b_reack", len_cycs[1] - reply_cycs[0], 1);

        // Reset while byte 1 of 3 sits in OUT
        clear_obs();
        @(posedge clk);
        #1 out_ready = 1'b0;
        post_msg(3, 8'h70, 8'h01, 1'b0);
        wait_valid("rst1", 40);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        wait_valid("rst2", 40);
        check("rst_one_byte", got_data.size(), 1);
        wr_snap = n_writes;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_async_valid", mb.out_valid, 1'b0);
        check("rst_async_cs", mb.mb_cs, 1'b0);
        check("rst_async_busy", busy, 1'b0);
        exp_data.delete();
        exp_last.delete();
        exp_reply.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(negedge clk);
        check("rst_no_reply", n_writes, wr_snap);
        check("rst_idle", busy, 1'b0);
        clear_obs();
        @(posedge clk);
        #1 out_ready = 1'b1;
        post_msg(3, 8'h90, 8'h03, 1'b0);
        wait_done("rst_fresh", 60);
        check("fresh_n", got_data.size(), 3);
        check("fresh_b0", got_data[0], 8'h90);
        check("fresh_b2", got_data[2], 8'h96);
        check("fresh_reply", got_reply[0], 8'h03);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
